ram_port_arbiter: RTL and testbench

- Shares the dual-read/single-write scratch RAM in the IO module between two requesters: A (IO loader) and B (solver core).
- Each accepted command is either one write or a pair of reads.
- Uses round-robin arbitration with a valid/ready handshake and returns read data with a registered valid strobe.
- Sits between the requesters and the RAM's WR_Enable, address_RD1/2, address_WR, dataIn, dataOut1/2 pins.

---
 rtl/ram_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares a dual-read/single-write scratch RAM between
// requester A (IO loader) and requester B (solver core).
// Round-robin arbitration, valid/ready handshake, registered read return.
// Optional burst locking is enabled by defining RAM_ARB_LOCK_EN.
module ram_port_arbiter #(
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH    = 64,
  parameter int DEPTH         = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     req_a,
  input  logic                     req_b,
  input  logic                     we_a,
  input  logic                     we_b,
  input  logic [ADDRESS_WIDTH-1:0] addr1_a,
  input  logic [ADDRESS_WIDTH-1:0] addr1_b,
  input  logic [ADDRESS_WIDTH-1:0] addr2_a,
  input  logic [ADDRESS_WIDTH-1:0] addr2_b,
  input  logic [DATA_WIDTH-1:0]    wdata_a,
  input  logic [DATA_WIDTH-1:0]    wdata_b,
  input  logic                     lock_a,
  input  logic                     lock_b,
  output logic                     gnt_a,
  output logic                     gnt_b,
  output logic                     rvalid_a,
  output logic                     rvalid_b,
  output logic [DATA_WIDTH-1:0]    rdata1,
  output logic [DATA_WIDTH-1:0]    rdata2,
  output logic                     ram_wr_en,
  output logic [ADDRESS_WIDTH-1:0] ram_addr_wr,
  output logic [ADDRESS_WIDTH-1:0] ram_addr_rd1,
  output logic [ADDRESS_WIDTH-1:0] ram_addr_rd2,
  output logic [DATA_WIDTH-1:0]    ram_wdata,
  input  logic [DATA_WIDTH-1:0]    ram_dout1,
  input  logic [DATA_WIDTH-1:0]    ram_dout2,
  output logic                     addr_err
);

  // One extra bit so DEPTH == 2**ADDRESS_WIDTH still compares correctly.
  localparam logic [ADDRESS_WIDTH:0] DEPTH_EXT = (ADDRESS_WIDTH + 1)'(DEPTH);

  logic                     prio_b_reg;   // 1: B wins the next tie
  logic                     block_a;
  logic                     block_b;
  logic                     xfer;
  logic                     sel_we;
  logic [ADDRESS_WIDTH-1:0] sel_addr1;
  logic [ADDRESS_WIDTH-1:0] sel_addr2;
  logic [DATA_WIDTH-1:0]    sel_wdata;
  logic                     oor1;
  logic                     oor2;
  logic                     rd_pend_a_reg;
  logic                     rd_pend_b_reg;
  logic                     zero1_reg;
  logic                     zero2_reg;

`ifdef RAM_ARB_LOCK_EN
  typedef enum logic [1:0] {LOCK_NONE, LOCK_A, LOCK_B} lock_state_t;
  lock_state_t lock_state_reg;
  lock_state_t lock_state_next;

  // Lock owner register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) lock_state_reg <= LOCK_NONE;
    else     lock_state_reg <= lock_state_next;
  end

  // Lock acquire on a locked transfer; release on an unlocked transfer or a req gap.
  always_comb begin
    lock_state_next = lock_state_reg;
    block_a         = 1'b0;
    block_b         = 1'b0;
    case (lock_state_reg)
      LOCK_NONE: begin
        if (gnt_a && lock_a)      lock_state_next = LOCK_A;
        else if (gnt_b && lock_b) lock_state_next = LOCK_B;
      end
      LOCK_A: begin
        block_b = 1'b1;
        if (!req_a || (gnt_a && !lock_a)) lock_state_next = LOCK_NONE;
      end
      LOCK_B: begin
        block_a = 1'b1;
        if (!req_b || (gnt_b && !lock_b)) lock_state_next = LOCK_NONE;
      end
      default: lock_state_next = LOCK_NONE;
    endcase
  end
`else
  // Lock inputs have no effect in this build.
  logic unused_lock;
  assign unused_lock = lock_a ^ lock_b;
  assign block_a     = 1'b0;
  assign block_b     = 1'b0;
`endif

  // Round-robin grant and selection of the winning command.
  always_comb begin
    gnt_a     = req_a && !block_a && (!(req_b && !block_b) || !prio_b_reg);
    gnt_b     = req_b && !block_b && (!(req_a && !block_a) ||  prio_b_reg);
    xfer      = gnt_a || gnt_b;
    sel_we    = gnt_b ? we_b    : we_a;
    sel_addr1 = gnt_b ? addr1_b : addr1_a;
    sel_addr2 = gnt_b ? addr2_b : addr2_a;
    sel_wdata = gnt_b ? wdata_b : wdata_a;
    oor1      = !({1'b0, sel_addr1} < DEPTH_EXT);
    oor2      = !sel_we && !({1'b0, sel_addr2} < DEPTH_EXT);
  end

  // Issue stage: drive RAM pins, remember which requester has a read in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prio_b_reg    <= 1'b0;
      ram_wr_en     <= 1'b0;
      ram_addr_wr   <= '0;
      ram_addr_rd1  <= '0;
      ram_addr_rd2  <= '0;
      ram_wdata     <= '0;
      rd_pend_a_reg <= 1'b0;
      rd_pend_b_reg <= 1'b0;
      zero1_reg     <= 1'b0;
      zero2_reg     <= 1'b0;
      addr_err      <= 1'b0;
    end else begin
      if (gnt_a)      prio_b_reg <= 1'b1;
      else if (gnt_b) prio_b_reg <= 1'b0;

      // Out-of-range writes never reach the RAM.
      ram_wr_en <= xfer && sel_we && !oor1;
      if (xfer && sel_we && !oor1) begin
        ram_addr_wr <= sel_addr1;
        ram_wdata   <= sel_wdata;
      end
      if (xfer && !sel_we) begin
        ram_addr_rd1 <= sel_addr1;
        ram_addr_rd2 <= sel_addr2;
      end

      rd_pend_a_reg <= gnt_a && !we_a;
      rd_pend_b_reg <= gnt_b && !we_b;
      zero1_reg     <= xfer && !sel_we && oor1;
      zero2_reg     <= oor2 && xfer;

      if (xfer && (oor1 || oor2)) addr_err <= 1'b1;
    end
  end

  // Return stage: capture RAM outputs one edge after issue and pulse rvalid.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
      rdata1   <= '0;
      rdata2   <= '0;
    end else begin
      rvalid_a <= rd_pend_a_reg;
      rvalid_b <= rd_pend_b_reg;
      if (rd_pend_a_reg || rd_pend_b_reg) begin
        rdata1 <= zero1_reg ? '0 : ram_dout1;
        rdata2 <= zero2_reg ? '0 : ram_dout2;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed testbench for ram_port_arbiter with a behavioural scratch RAM:
// writes commit on the rising edge, read outputs update on the falling edge.
// Define RAM_ARB_LOCK_EN to also exercise the lock scenario.
module tb_ram_port_arbiter;
  localparam int AW = 13;
  localparam int DW = 64;

  logic          CLK, RST;
  logic          req_a, req_b, we_a, we_b, lock_a, lock_b;
  logic [AW-1:0] addr1_a, addr1_b, addr2_a, addr2_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic          gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [DW-1:0] rdata1, rdata2;
  logic          ram_wr_en;
  logic [AW-1:0] ram_addr_wr, ram_addr_rd1, ram_addr_rd2;
  logic [DW-1:0] ram_wdata, ram_dout1, ram_dout2;
  logic          addr_err;

  int checks = 0;
  int errors = 0;

  ram_port_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(16)) dut (
    .CLK(CLK), .RST(RST),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr1_a(addr1_a), .addr1_b(addr1_b), .addr2_a(addr2_a), .addr2_b(addr2_b),
    .wdata_a(wdata_a), .wdata_b(wdata_b), .lock_a(lock_a), .lock_b(lock_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .rdata1(rdata1), .rdata2(rdata2), .ram_wr_en(ram_wr_en),
    .ram_addr_wr(ram_addr_wr), .ram_addr_rd1(ram_addr_rd1), .ram_addr_rd2(ram_addr_rd2),
    .ram_wdata(ram_wdata), .ram_dout1(ram_dout1), .ram_dout2(ram_dout2),
    .addr_err(addr_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // RAM model: word i starts as i*0x1111; out-of-range reads return a garbage pattern.
  logic [DW-1:0] mem [16];
  bit            mem_init;
  always @(posedge CLK) begin
    if (!mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= DW'(i) * 64'h1111;
      mem_init <= 1'b1;
    end else if (ram_wr_en && ram_addr_wr < 16) begin
      mem[ram_addr_wr[3:0]] <= ram_wdata;
    end
  end
  always @(negedge CLK) begin
    ram_dout1 <= (ram_addr_rd1 < 16) ? mem[ram_addr_rd1[3:0]] : 64'hBAD0_BAD0_BAD0_BAD0;
    ram_dout2 <= (ram_addr_rd2 < 16) ? mem[ram_addr_rd2[3:0]] : 64'hBAD0_BAD0_BAD0_BAD0;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    req_a = 0; req_b = 0; we_a = 0; we_b = 0; lock_a = 0; lock_b = 0;
    addr1_a = '0; addr1_b = '0; addr2_a = '0; addr2_b = '0;
    wdata_a = '0; wdata_b = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    RST = 1;
    step(); step();
    checks++;
    if ({ram_wr_en, rvalid_a, rvalid_b, addr_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=0000", {ram_wr_en, rvalid_a, rvalid_b, addr_err});
    end
    checks++;
    if (rdata1 !== '0 || ram_addr_rd1 !== '0 || ram_wdata !== '0) begin
      errors++;
      $display("FAIL reset_data rdata1=%h rd1=%h wdata=%h exp=0", rdata1, ram_addr_rd1, ram_wdata);
    end
    RST = 0;
    // Start a read, then reset while it is in flight.
    req_a = 1; we_a = 0; addr1_a = 1; addr2_a = 2;
    step();
    req_a = 0;
    RST = 1;
    #1;
    checks++;
    if (rvalid_a !== 1'b0 || ram_wr_en !== 1'b0 || addr_err !== 1'b0 || ram_addr_rd1 !== '0) begin
      errors++;
      $display("FAIL reset_midread rvalid_a=%b wr_en=%b err=%b rd1=%h exp=0", rvalid_a, ram_wr_en, addr_err, ram_addr_rd1);
    end
    step(); step();
    RST = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0) begin
        errors++;
        $display("FAIL reset_stale cyc=%0d rvalid_a=%b rvalid_b=%b exp=0", i, rvalid_a, rvalid_b);
      end
    end
    $display("reset test done");
  endtask

  task automatic test_contention();
    logic ea, eb;
    req_a = 1; we_a = 0; addr1_a = 1; addr2_a = 2;
    req_b = 1; we_b = 0; addr1_b = 7; addr2_b = 8;
    for (int i = 0; i < 6; i++) begin
      if (i >= 4) begin req_a = 0; req_b = 0; end
      #1;
      if (i < 4) begin
        ea = (i % 2 == 0);
        eb = !ea;
        checks++;
        if (gnt_a !== ea || gnt_b !== eb) begin
          errors++;
          $display("FAIL cont_gnt cyc=%0d gnt_a=%b gnt_b=%b exp=%b%b", i, gnt_a, gnt_b, ea, eb);
        end
      end
      step();
      ea = (i == 1 || i == 3);
      eb = (i == 2 || i == 4);
      checks++;
      if (rvalid_a !== ea || rvalid_b !== eb) begin
        errors++;
        $display("FAIL cont_rvalid cyc=%0d rvalid_a=%b rvalid_b=%b exp=%b%b", i, rvalid_a, rvalid_b, ea, eb);
      end
      if (ea) begin
        checks++;
        if (rdata1 !== 64'h1111 || rdata2 !== 64'h2222) begin
          errors++;
          $display("FAIL cont_rdata_a cyc=%0d got=%h/%h exp=1111/2222", i, rdata1, rdata2);
        end
      end
      if (eb) begin
        checks++;
        if (rdata1 !== 64'h7777 || rdata2 !== 64'h8888) begin
          errors++;
          $display("FAIL cont_rdata_b cyc=%0d got=%h/%h exp=7777/8888", i, rdata1, rdata2);
        end
      end
    end
    idle_inputs();
    $display("contention test done");
  endtask

  task automatic test_single_write_read();
    #1;
    checks++;
    if (gnt_a !== 1'b0 || gnt_b !== 1'b0) begin
      errors++;
      $display("FAIL idle_gnt gnt_a=%b gnt_b=%b exp=00", gnt_a, gnt_b);
    end
    req_a = 1; we_a = 1; addr1_a = 3; wdata_a = 64'hDEADBEEF_00000001;
    step();
    req_a = 0;
    checks++;
    if (ram_wr_en !== 1'b1 || ram_addr_wr !== 13'd3 || ram_wdata !== 64'hDEADBEEF_00000001) begin
      errors++;
      $display("FAIL wr_issue wr_en=%b addr=%0d data=%h exp=1/3/deadbeef00000001", ram_wr_en, ram_addr_wr, ram_wdata);
    end
    step();
    checks++;
    if (ram_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL wr_pulse wr_en=%b exp=0", ram_wr_en);
    end
    req_a = 1; we_a = 0; addr1_a = 3; addr2_a = 0;
    step();
    req_a = 0;
    checks++;
    if (rvalid_a !== 1'b0 || ram_addr_rd1 !== 13'd3 || ram_addr_rd2 !== 13'd0) begin
      errors++;
      $display("FAIL rd_issue rvalid_a=%b rd1=%0d rd2=%0d exp=0/3/0", rvalid_a, ram_addr_rd1, ram_addr_rd2);
    end
    step();
    checks++;
    if (rvalid_a !== 1'b1 || rdata1 !== 64'hDEADBEEF_00000001 || rdata2 !== 64'h0) begin
      errors++;
      $display("FAIL rd_return rvalid_a=%b rdata1=%h rdata2=%h exp=1/deadbeef00000001/0", rvalid_a, rdata1, rdata2);
    end
    step();
    checks++;
    if (rvalid_a !== 1'b0) begin
      errors++;
      $display("FAIL rd_pulse rvalid_a=%b exp=0", rvalid_a);
    end
    idle_inputs();
    $display("single write/read test done");
  endtask

  task automatic test_read_after_write();
    req_a = 1; we_a = 1; addr1_a = 5; wdata_a = 64'h55;
    step();
    req_a = 0;
    req_b = 1; we_b = 0; addr1_b = 5; addr2_b = 1;
    #1;
    checks++;
    if (gnt_b !== 1'b1) begin
      errors++;
      $display("FAIL raw_gnt gnt_b=%b exp=1", gnt_b);
    end
    step();
    req_b = 0;
    step();
    checks++;
    if (rvalid_b !== 1'b1 || rvalid_a !== 1'b0 || rdata1 !== 64'h55 || rdata2 !== 64'h1111) begin
      errors++;
      $display("FAIL raw_data rvalid_b=%b rvalid_a=%b rdata1=%h rdata2=%h exp=1/0/55/1111", rvalid_b, rvalid_a, rdata1, rdata2);
    end
    idle_inputs();
    step();
    $display("read-after-write test done");
  endtask

  task automatic test_out_of_range();
    checks++;
    if (addr_err !== 1'b0) begin
      errors++;
      $display("FAIL oor_pre addr_err=%b exp=0", addr_err);
    end
    req_a = 1; we_a = 1; addr1_a = 16; wdata_a = 64'hFFFF;
    step();
    req_a = 0;
    checks++;
    if (ram_wr_en !== 1'b0 || addr_err !== 1'b1) begin
      errors++;
      $display("FAIL oor_write wr_en=%b addr_err=%b exp=0/1", ram_wr_en, addr_err);
    end
    step();
    req_a = 1; we_a = 0; addr1_a = 1; addr2_a = 20;
    step();
    req_a = 0;
    step();
    checks++;
    if (rvalid_a !== 1'b1 || rdata1 !== 64'h1111 || rdata2 !== 64'h0 || addr_err !== 1'b1) begin
      errors++;
      $display("FAIL oor_read rvalid_a=%b rdata1=%h rdata2=%h err=%b exp=1/1111/0/1", rvalid_a, rdata1, rdata2, addr_err);
    end
    step(); step();
    checks++;
    if (addr_err !== 1'b1) begin
      errors++;
      $display("FAIL oor_sticky addr_err=%b exp=1", addr_err);
    end
    idle_inputs();
    $display("out-of-range test done");
  endtask

`ifdef RAM_ARB_LOCK_EN
  task automatic test_lock();
    // A acquires alone, then B competes during the locked burst.
    req_a = 1; we_a = 1; lock_a = 1; addr1_a = 10; wdata_a = 64'hA0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) lock_a = 0;
      #1;
      checks++;
      if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin
        errors++;
        $display("FAIL lock_hold cyc=%0d gnt_a=%b gnt_b=%b exp=10", i, gnt_a, gnt_b);
      end
      step();
      req_b = 1; we_b = 0; addr1_b = 2; addr2_b = 3;
      addr1_a = AW'(11 + i); wdata_a = DW'(64'hA1 + i);
    end
    #1;
    checks++;
    if (gnt_b !== 1'b1 || gnt_a !== 1'b0) begin
      errors++;
      $display("FAIL lock_release gnt_a=%b gnt_b=%b exp=01", gnt_a, gnt_b);
    end
    idle_inputs();
    step(); step(); step();
    $display("lock test done");
  endtask
`endif

  initial begin
    RST = 1;
    idle_inputs();
    test_reset();
    test_contention();
    test_single_write_read();
    test_read_after_write();
    test_out_of_range();
`ifdef RAM_ARB_LOCK_EN
    test_lock();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Grants must never overlap.
  always @(negedge CLK) begin
    if (!RST && gnt_a && gnt_b) begin
      errors++;
      $display("FAIL gnt_exclusive gnt_a=%b gnt_b=%b exp=not both", gnt_a, gnt_b);
    end
  end

endmodule
